bp_train_scheduler: RTL and testbench
=====================================

// Module: bp_train_scheduler
//
// PURPOSE
// Shares the branch predictor's single weight-table port between decode-stage
// prediction lookups and execute-stage training updates. Feedback arriving from
// EX is buffered in a small FIFO and drained into the predictor on idle lookup
// cycles. A starvation guard forces a training slot, and stalls decode, when
// training has waited too long. Sits between branch_controller and the
// predictor core.
//
// PARAMETERS
// IDX_BITS    7   table index width; idx = pc[IDX_BITS+1:2]
// DEPTH       4   feedback FIFO entries, power of 2, >= 2
// STARVE_MAX  8   wait cycles with a pending entry before a training slot is forced
// CNT_BITS    16  width of the statistics counters
//
// PORTS
// clk              in   1         clock
// rst_n            in   1         async active-low reset
// i_req_valid      in   1         decode requests a prediction lookup
// i_req_pc         in   ADDR_W    PC of the branch in decode
// o_req_stall      out  1         lookup refused this cycle; decode holds
// o_tbl_rd_en      out  1         lookup granted on the table port
// o_tbl_rd_idx     out  IDX_BITS  lookup index
// i_fb_valid       in   1         EX branch result valid (one-cycle pulse)
// i_fb_pc          in   ADDR_W    PC of the resolved branch
// i_fb_prediction  in   1         prediction made (BranchOutcome)
// i_fb_outcome     in   1         actual outcome (BranchOutcome)
// o_trn_valid      out  1         training update offered to the predictor
// o_trn_idx        out  IDX_BITS  training index
// o_trn_outcome    out  1         outcome for the training update
// o_trn_mispred    out  1         prediction != outcome for this entry
// i_trn_ready      in   1         predictor accepts the update this cycle
// o_miss_count     out  CNT_BITS  accepted mispredicted feedbacks, saturating
// o_drop_count     out  CNT_BITS  feedbacks dropped because the FIFO was full, saturating
//
// BEHAVIOUR
// - Reset (async, rst_n=0): FIFO empty, starve counter 0, state IDLE, both stats
//   counters 0, every output 0. Reset mid-drain discards all pending entries.
// - States:
//   - IDLE: FIFO empty.
//   - DRAIN: FIFO non-empty.
//   - FORCE: starvation slot.
//   - Transitions:
//     - IDLE->DRAIN on push.
//     - DRAIN->IDLE when the last entry pops with no push in the same cycle.
//     - DRAIN->FORCE when the starve counter reaches STARVE_MAX.
//     - FORCE->DRAIN or FORCE->IDLE on pop, chosen by the post-pop occupancy.
// - Port grant, combinational, one user per cycle:
//   - IDLE or DRAIN with i_req_valid=1: o_tbl_rd_en=1, idx=i_req_pc[IDX_BITS+1:2],
//     o_req_stall=0, o_trn_valid=0.
//   - DRAIN with i_req_valid=0: o_trn_valid=1.
//   - FORCE: o_trn_valid=1, o_tbl_rd_en=0, o_req_stall=i_req_valid.
// - Training handshake:
//   - o_trn_* reflects the registered FIFO head.
//   - The entry pops when o_trn_valid & i_trn_ready.
//   - While o_trn_valid=1 and not ready, idx/outcome/mispred hold stable.
//   - A withdrawn offer (a lookup takes the port) does not pop the entry.
// - Push:
//   - On i_fb_valid with FIFO not full, or full with a pop in the same cycle,
//     the entry {i_fb_pc[IDX_BITS+1:2], outcome, prediction!=outcome} is written.
//   - Occupancy is unchanged on a simultaneous push and pop.
//   - On full with no pop: entry dropped, o_drop_count+1.
// - Latency: a feedback pushed at cycle t into an empty FIFO is offered at t+1
//   at the earliest. There is no same-cycle bypass.
// - o_miss_count: +1 on each accepted push with mispred=1. Dropped entries are
//   not counted as misses.
// - Starve counter:
//   - +1 each cycle the FIFO is non-empty and no pop occurs.
//   - Clears on pop or when the FIFO is empty.
//   - Saturates at STARVE_MAX.
// - Pointers: log2(DEPTH) bits plus a wrap bit; full/empty are decided by the wrap bit.
// - Stats counters saturate at all-ones and never wrap.
//
// TESTING
// 1. Reset: rst_n=0 asserted mid-cycle -> all outputs 0 immediately; after release,
//    FIFO empty and counters 0.
// 2. Idle drain: i_req_valid=0, fb pc=0x40 TAKEN/pred NOT_TAKEN, i_trn_ready=1 ->
//    next cycle o_trn_valid=1, idx=0x10, mispred=1, pop; o_miss_count=1.
// 3. Priority: i_req_valid=1 for 5 cycles with 1 entry pending -> o_tbl_rd_en=1 each
//    cycle, o_trn_valid=0, no stall.
// 4. Starvation: i_req_valid held 1, 1 entry pending, STARVE_MAX=8 -> after 8 wait
//    cycles FORCE: o_req_stall=1 and o_trn_valid=1 for 1 cycle; lookups resume the
//    cycle after the pop.
// 5. Overflow: DEPTH=4, i_trn_ready=0, 6 fb pulses -> 4 stored, o_drop_count=2; then
//    ready=1 -> entries emerge in push order.
// 6. Full+push+pop: FIFO full, i_fb_valid and pop in the same cycle -> occupancy stays
//    4, no drop, new entry emerges last.

Source files
------------

// File: rtl/bp_train_scheduler_if.sv
// rtl/bp_train_scheduler_if.sv - lookup, feedback and training port bundle of bp_train_scheduler
interface bp_train_scheduler_if #(
    parameter int ADDR_W   = 32,
    parameter int IDX_BITS = 7,
    parameter int CNT_BITS = 16
);
    logic                i_req_valid;
    logic [ADDR_W-1:0]   i_req_pc;
    logic                o_req_stall;
    logic                o_tbl_rd_en;
    logic [IDX_BITS-1:0] o_tbl_rd_idx;
    logic                i_fb_valid;
    logic [ADDR_W-1:0]   i_fb_pc;
    logic                i_fb_prediction;
    logic                i_fb_outcome;
    logic                o_trn_valid;
    logic [IDX_BITS-1:0] o_trn_idx;
    logic                o_trn_outcome;
    logic                o_trn_mispred;
    logic                i_trn_ready;
    logic [CNT_BITS-1:0] o_miss_count;
    logic [CNT_BITS-1:0] o_drop_count;

    modport slave (
        input  i_req_valid, i_req_pc, i_fb_valid, i_fb_pc, i_fb_prediction,
               i_fb_outcome, i_trn_ready,
        output o_req_stall, o_tbl_rd_en, o_tbl_rd_idx, o_trn_valid, o_trn_idx,
               o_trn_outcome, o_trn_mispred, o_miss_count, o_drop_count
    );

    modport master (
        output i_req_valid, i_req_pc, i_fb_valid, i_fb_pc, i_fb_prediction,
               i_fb_outcome, i_trn_ready,
        input  o_req_stall, o_tbl_rd_en, o_tbl_rd_idx, o_trn_valid, o_trn_idx,
               o_trn_outcome, o_trn_mispred, o_miss_count, o_drop_count
    );
endinterface

// File: rtl/bp_train_scheduler.sv
// rtl/bp_train_scheduler.sv - arbitrates the predictor table port between lookups and buffered training
module bp_train_scheduler #(
    parameter int ADDR_W     = 32,
    parameter int IDX_BITS   = 7,
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8,
    parameter int CNT_BITS   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bp_train_scheduler_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = IDX_BITS + 2;
    localparam int ST_W  = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, DRAIN, FORCE} state_t;

    state_t              state_q;
    logic [ENT_W-1:0]    mem_q [DEPTH];
    logic [PTR_W:0]      wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
    logic [ST_W-1:0]     starve_q, starve_d;
    logic [CNT_BITS-1:0] miss_q, drop_q;

    logic fifo_empty, fifo_full, fifo_empty_d;
    logic rd_en, trn_valid, stall;
    logic push, pop, drop, fb_mispred;
    logic [ENT_W-1:0] head;
    logic unused_pc_bits;

    assign unused_pc_bits = ^{bus.i_req_pc[ADDR_W-1:IDX_BITS+2], bus.i_req_pc[1:0],
                              bus.i_fb_pc[ADDR_W-1:IDX_BITS+2], bus.i_fb_pc[1:0]};

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

    // One table-port user per cycle; FORCE takes the port regardless of decode.
    always_comb begin
        rd_en     = 1'b0;
        trn_valid = 1'b0;
        stall     = 1'b0;
        unique case (state_q)
            IDLE:  rd_en = bus.i_req_valid & rst_n;
            DRAIN: begin
                rd_en     = bus.i_req_valid & rst_n;
                trn_valid = ~bus.i_req_valid;
            end
            FORCE: begin
                trn_valid = 1'b1;
                stall     = bus.i_req_valid;
            end
            default: ;
        endcase
    end

    assign pop        = trn_valid & bus.i_trn_ready;
    assign push       = bus.i_fb_valid & (~fifo_full | pop);
    assign drop       = bus.i_fb_valid & fifo_full & ~pop;
    assign fb_mispred = bus.i_fb_prediction ^ bus.i_fb_outcome;

    assign wr_ptr_d     = wr_ptr_q + (PTR_W+1)'(push);
    assign rd_ptr_d     = rd_ptr_q + (PTR_W+1)'(pop);
    assign fifo_empty_d = (wr_ptr_d == rd_ptr_d);

    always_comb begin
        starve_d = starve_q;
        if (pop || fifo_empty)
            starve_d = '0;
        else if (starve_q < ST_W'(STARVE_MAX))
            starve_d = starve_q + ST_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            starve_q <= '0;
            miss_q   <= '0;
            drop_q   <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
        end else begin
            // On full+push+pop the write lands in the slot the head vacates this cycle.
            if (push)
                mem_q[wr_ptr_q[PTR_W-1:0]] <= {bus.i_fb_pc[IDX_BITS+1:2], bus.i_fb_outcome, fb_mispred};
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            starve_q <= starve_d;
            if (push && fb_mispred && (miss_q != '1))
                miss_q <= miss_q + CNT_BITS'(1);
            if (drop && (drop_q != '1))
                drop_q <= drop_q + CNT_BITS'(1);
            unique case (state_q)
                IDLE:  if (push) state_q <= DRAIN;
                DRAIN: begin
                    if (fifo_empty_d)
                        state_q <= IDLE;
                    else if (starve_d == ST_W'(STARVE_MAX))
                        state_q <= FORCE;
                end
                FORCE: if (pop) state_q <= fifo_empty_d ? IDLE : DRAIN;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign head = mem_q[rd_ptr_q[PTR_W-1:0]];

    assign bus.o_req_stall   = stall;
    assign bus.o_tbl_rd_en   = rd_en;
    assign bus.o_tbl_rd_idx  = rd_en ? bus.i_req_pc[IDX_BITS+1:2] : '0;
    assign bus.o_trn_valid   = trn_valid;
    assign bus.o_trn_idx     = head[ENT_W-1:2];
    assign bus.o_trn_outcome = head[1];
    assign bus.o_trn_mispred = head[0];
    assign bus.o_miss_count  = miss_q;
    assign bus.o_drop_count  = drop_q;
endmodule

// File: tb/tb_bp_train_scheduler.sv
// tb/tb_bp_train_scheduler.sv - vector table, corner sequences and queue-model random run for bp_train_scheduler
module tb_bp_train_scheduler;
    localparam int ADDR_W     = 32;
    localparam int IDX_BITS   = 7;
    localparam int DEPTH      = 4;
    localparam int STARVE_MAX = 8;
    localparam int CNT_BITS   = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bp_train_scheduler_if #(.ADDR_W(ADDR_W), .IDX_BITS(IDX_BITS), .CNT_BITS(CNT_BITS)) bus ();

    bp_train_scheduler #(.ADDR_W(ADDR_W), .IDX_BITS(IDX_BITS), .DEPTH(DEPTH),
                         .STARVE_MAX(STARVE_MAX), .CNT_BITS(CNT_BITS))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          rv;  logic [31:0] rpc;
        bit          fv;  logic [31:0] fpc; bit fp; bit fo;
        bit          rdy;
        bit          e_rd; logic [6:0] e_ridx; bit e_stall;
        bit          e_tv; logic [6:0] e_tidx; bit e_tout; bit e_tmis;
        int          e_miss; int e_drop;
    } vec_t;

    typedef struct {
        logic [6:0] idx;
        bit         outcome;
        bit         mis;
    } ent_t;

    vec_t vt[9];
    ent_t mq[$];
    int   m_wait, m_miss, m_drop;
    logic [6:0] exp_order[4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic set_in(input bit rv, input logic [31:0] rpc, input bit fv, input logic [31:0] fpc,
                          input bit fp, input bit fo, input bit rdy);
        bus.i_req_valid     = rv;
        bus.i_req_pc        = rpc;
        bus.i_fb_valid      = fv;
        bus.i_fb_pc         = fpc;
        bus.i_fb_prediction = fp;
        bus.i_fb_outcome    = fo;
        bus.i_trn_ready     = rdy;
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        bit rv, fv, fp, fo, rdy, forced, e_tv, e_rd, e_st, pop;
        logic [31:0] rpc, fpc;
        int rq_pct, fb_pct, rdy_pct;

        // Reset release, then reset asserted mid-cycle with entries pending.
        set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_trn_valid", 32'(bus.o_trn_valid), 32'h0);
        chk("rst_miss", 32'(bus.o_miss_count), 32'h0);
        next_cycle();
        set_in(1'b0, 32'h0, 1'b1, 32'h44, 1'b0, 1'b1, 1'b0);
        next_cycle();
        set_in(1'b0, 32'h0, 1'b1, 32'h48, 1'b1, 1'b1, 1'b0);
        next_cycle();
        set_in(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("pre_rst_miss", 32'(bus.o_miss_count), 32'h1);
        chk("pre_rst_rd_en", 32'(bus.o_tbl_rd_en), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_rd_en", 32'(bus.o_tbl_rd_en), 32'h0);
        chk("midrst_rd_idx", 32'(bus.o_tbl_rd_idx), 32'h0);
        chk("midrst_stall", 32'(bus.o_req_stall), 32'h0);
        chk("midrst_trn_valid", 32'(bus.o_trn_valid), 32'h0);
        chk("midrst_trn_idx", 32'(bus.o_trn_idx), 32'h0);
        chk("midrst_trn_out", 32'(bus.o_trn_outcome), 32'h0);
        chk("midrst_trn_mis", 32'(bus.o_trn_mispred), 32'h0);
        chk("midrst_miss", 32'(bus.o_miss_count), 32'h0);
        chk("midrst_drop", 32'(bus.o_drop_count), 32'h0);
        set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        chk("postrst_empty", 32'(bus.o_trn_valid), 32'h0);
        next_cycle();

        // Idle drain, then lookup priority over a pending entry.
        vt[0] = '{1'b0, 32'h0,    1'b1, 32'h40, 1'b0, 1'b1, 1'b1, 1'b0, 7'h00, 1'b0, 1'b0, 7'h00, 1'b0, 1'b0, 0, 0};
        vt[1] = '{1'b0, 32'h0,    1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 7'h00, 1'b0, 1'b1, 7'h10, 1'b1, 1'b1, 1, 0};
        vt[2] = '{1'b1, 32'h1234, 1'b1, 32'h88, 1'b1, 1'b1, 1'b1, 1'b1, 7'h0D, 1'b0, 1'b0, 7'h00, 1'b0, 1'b0, 1, 0};
        vt[3] = '{1'b1, 32'h2004, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b1, 7'h01, 1'b0, 1'b0, 7'h00, 1'b0, 1'b0, 1, 0};
        vt[4] = '{1'b1, 32'h2008, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b1, 7'h02, 1'b0, 1'b0, 7'h00, 1'b0, 1'b0, 1, 0};
        vt[5] = '{1'b1, 32'h200C, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b1, 7'h03, 1'b0, 1'b0, 7'h00, 1'b0, 1'b0, 1, 0};
        vt[6] = '{1'b1, 32'h2010, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b1, 7'h04, 1'b0, 1'b0, 7'h00, 1'b0, 1'b0, 1, 0};
        vt[7] = '{1'b1, 32'h2014, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b1, 7'h05, 1'b0, 1'b0, 7'h00, 1'b0, 1'b0, 1, 0};
        vt[8] = '{1'b0, 32'h0,    1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 7'h00, 1'b0, 1'b1, 7'h22, 1'b1, 1'b0, 1, 0};
        for (int i = 0; i < 9; i++) begin
            set_in(vt[i].rv, vt[i].rpc, vt[i].fv, vt[i].fpc, vt[i].fp, vt[i].fo, vt[i].rdy);
            @(negedge clk);
            chk($sformatf("vec%0d_rd_en", i), 32'(bus.o_tbl_rd_en), 32'(vt[i].e_rd));
            chk($sformatf("vec%0d_stall", i), 32'(bus.o_req_stall), 32'(vt[i].e_stall));
            chk($sformatf("vec%0d_trn_valid", i), 32'(bus.o_trn_valid), 32'(vt[i].e_tv));
            chk($sformatf("vec%0d_miss", i), 32'(bus.o_miss_count), 32'(vt[i].e_miss));
            chk($sformatf("vec%0d_drop", i), 32'(bus.o_drop_count), 32'(vt[i].e_drop));
            if (vt[i].e_rd)
                chk($sformatf("vec%0d_rd_idx", i), 32'(bus.o_tbl_rd_idx), 32'(vt[i].e_ridx));
            if (vt[i].e_tv) begin
                chk($sformatf("vec%0d_trn_idx", i), 32'(bus.o_trn_idx), 32'(vt[i].e_tidx));
                chk($sformatf("vec%0d_trn_out", i), 32'(bus.o_trn_outcome), 32'(vt[i].e_tout));
                chk($sformatf("vec%0d_trn_mis", i), 32'(bus.o_trn_mispred), 32'(vt[i].e_tmis));
            end
            next_cycle();
        end

        // Starvation: lookups held for 8 wait cycles, then one forced training slot.
        do_reset();
        set_in(1'b1, 32'h200, 1'b1, 32'h100, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("starve_push_rd_en", 32'(bus.o_tbl_rd_en), 32'h1);
        next_cycle();
        for (int k = 1; k <= STARVE_MAX; k++) begin
            set_in(1'b1, 32'h200 + 32'(4 * k), 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
            @(negedge clk);
            chk($sformatf("starve_w%0d_rd_en", k), 32'(bus.o_tbl_rd_en), 32'h1);
            chk($sformatf("starve_w%0d_trn_valid", k), 32'(bus.o_trn_valid), 32'h0);
            chk($sformatf("starve_w%0d_stall", k), 32'(bus.o_req_stall), 32'h0);
            next_cycle();
        end
        set_in(1'b1, 32'h300, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("force_stall", 32'(bus.o_req_stall), 32'h1);
        chk("force_trn_valid", 32'(bus.o_trn_valid), 32'h1);
        chk("force_rd_en", 32'(bus.o_tbl_rd_en), 32'h0);
        chk("force_trn_idx", 32'(bus.o_trn_idx), 32'h40);
        next_cycle();
        @(negedge clk);
        chk("resume_rd_en", 32'(bus.o_tbl_rd_en), 32'h1);
        chk("resume_stall", 32'(bus.o_req_stall), 32'h0);
        chk("resume_trn_valid", 32'(bus.o_trn_valid), 32'h0);
        next_cycle();

        // Overflow with ready low, then full+push+pop, then drain order.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            set_in(1'b0, 32'h0, 1'b1, 32'hC0 + 32'(4 * i), i[0], 1'b0, 1'b0);
            @(negedge clk);
            if (i > 0) begin
                chk($sformatf("ovf%0d_trn_valid", i), 32'(bus.o_trn_valid), 32'h1);
                chk($sformatf("ovf%0d_hold_idx", i), 32'(bus.o_trn_idx), 32'h30);
            end
            next_cycle();
        end
        set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("ovf_drop", 32'(bus.o_drop_count), 32'h2);
        chk("ovf_miss", 32'(bus.o_miss_count), 32'h2);
        chk("ovf_hold_idx", 32'(bus.o_trn_idx), 32'h30);
        next_cycle();
        set_in(1'b0, 32'h0, 1'b1, 32'hF0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        chk("fpp_trn_valid", 32'(bus.o_trn_valid), 32'h1);
        chk("fpp_trn_idx", 32'(bus.o_trn_idx), 32'h30);
        next_cycle();
        exp_order[0] = 7'h31; exp_order[1] = 7'h32; exp_order[2] = 7'h33; exp_order[3] = 7'h3C;
        for (int j = 0; j < 4; j++) begin
            set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
            @(negedge clk);
            chk($sformatf("drain%0d_trn_valid", j), 32'(bus.o_trn_valid), 32'h1);
            chk($sformatf("drain%0d_trn_idx", j), 32'(bus.o_trn_idx), 32'(exp_order[j]));
            next_cycle();
        end
        @(negedge clk);
        chk("drain_empty", 32'(bus.o_trn_valid), 32'h0);
        chk("fpp_drop", 32'(bus.o_drop_count), 32'h2);
        chk("fpp_miss", 32'(bus.o_miss_count), 32'h3);
        next_cycle();

        // Random traffic against a queue-based model of the scheduling rules.
        do_reset();
        mq.delete();
        m_wait = 0; m_miss = 0; m_drop = 0;
        for (int c = 0; c < 800; c++) begin
            case ((c / 100) % 4)
                0: begin rq_pct = 60; fb_pct = 40; rdy_pct = 70; end
                1: begin rq_pct = 95; fb_pct = 30; rdy_pct = 80; end
                2: begin rq_pct = 30; fb_pct = 70; rdy_pct = 20; end
                default: begin rq_pct = 80; fb_pct = 60; rdy_pct = 50; end
            endcase
            rv  = ($urandom_range(99) < rq_pct);
            fv  = ($urandom_range(99) < fb_pct);
            rdy = ($urandom_range(99) < rdy_pct);
            fp  = $urandom_range(1) == 1;
            fo  = $urandom_range(1) == 1;
            rpc = $urandom();
            fpc = $urandom();
            set_in(rv, rpc, fv, fpc, fp, fo, rdy);
            @(negedge clk);
            forced = (mq.size() != 0) && (m_wait >= STARVE_MAX);
            e_tv   = (mq.size() != 0) && (forced || !rv);
            e_rd   = rv && !forced;
            e_st   = rv && forced;
            chk("rnd_rd_en", 32'(bus.o_tbl_rd_en), 32'(e_rd));
            chk("rnd_stall", 32'(bus.o_req_stall), 32'(e_st));
            chk("rnd_trn_valid", 32'(bus.o_trn_valid), 32'(e_tv));
            chk("rnd_miss", 32'(bus.o_miss_count), 32'(m_miss));
            chk("rnd_drop", 32'(bus.o_drop_count), 32'(m_drop));
            if (e_rd)
                chk("rnd_rd_idx", 32'(bus.o_tbl_rd_idx), 32'(rpc[8:2]));
            if (e_tv) begin
                chk("rnd_trn_idx", 32'(bus.o_trn_idx), 32'(mq[0].idx));
                chk("rnd_trn_out", 32'(bus.o_trn_outcome), 32'(mq[0].outcome));
                chk("rnd_trn_mis", 32'(bus.o_trn_mispred), 32'(mq[0].mis));
            end
            pop = e_tv && rdy;
            if (pop || mq.size() == 0)
                m_wait = 0;
            else if (m_wait < STARVE_MAX)
                m_wait++;
            if (pop)
                void'(mq.pop_front());
            if (fv) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back('{fpc[8:2], fo, fp != fo});
                    if (fp != fo && m_miss < 65535) m_miss++;
                end else if (m_drop < 65535) begin
                    m_drop++;
                end
            end
            next_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
